// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the sliced up/down counter
package counter_pkg;

   localparam int SLICE_W = 4;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Number of 4-bit slices needed to build a counter of the given width
   function automatic int slice_count(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/counter_slice.sv
// rtl/counter_slice.sv - 4-bit up/down loadable counter slice with terminal decodes
module counter_slice
   import counter_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               ud,
   input  logic               ld,
   input  logic [SLICE_W-1:0] din,
   input  logic [SLICE_W-1:0] rst_val,
   output logic [SLICE_W-1:0] q,
   output logic               tc_up,
   output logic               tc_dn
);

   // Slice register: load wins over count; reset value comes from the parent's parameter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= rst_val;
      end else if (ld) begin
         q <= din;
      end else if (ce) begin
         if (ud) begin
            q <= q + SLICE_W'(1);
         end else begin
            q <= q - SLICE_W'(1);
         end
      end
   end

   // Carry/borrow out of this slice: all ones going up, all zeros going down
   assign tc_up = (q == {SLICE_W{1'b1}});
   assign tc_dn = (q == '0);

endmodule

// File: rtl/counter_udl_param.sv
// rtl/counter_udl_param.sv - parametrised up/down loadable modulo counter with wrap/saturate
module counter_udl_param
   import counter_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             ud,
   input  logic             ld,
   input  logic             clr,
   input  logic             sat,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] q,
   output logic             utc,
   output logic             dtc,
   output logic             wrap,
   output logic             ovf
);

   localparam int NS = slice_count(WIDTH);

   logic [NS-1:0]    s_tc_up;
   logic [NS-1:0]    s_tc_dn;
   logic [NS-1:0]    s_ce;
   logic             step_en;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic             set_wrap;
   logic             set_ovf;

   // The all-ones count is terminal for any limit, so the full carry chain feeds utc too.
   assign utc = (&s_tc_up) | (q >= limit);
   assign dtc = &s_tc_dn;

   // Decode the edge's action: clear and wrap become loads into the slices, a normal
   // step goes through the carry chain, a saturated terminal attempt only raises ovf.
   always_comb begin
      step_en  = 1'b0;
      load_en  = 1'b0;
      load_val = '0;
      set_wrap = 1'b0;
      set_ovf  = 1'b0;
      if (clr) begin
         load_en  = 1'b1;
         load_val = '0;
      end else if (ld) begin
         load_en  = 1'b1;
         load_val = din;
      end else if (ce) begin
         if (ud) begin
            if (!utc) begin
               step_en = 1'b1;
            end else if (sat == MODE_SAT) begin
               set_ovf = 1'b1;
            end else begin
               load_en  = 1'b1;
               load_val = '0;
               set_wrap = 1'b1;
            end
         end else begin
            if (!dtc) begin
               step_en = 1'b1;
            end else if (sat == MODE_SAT) begin
               set_ovf = 1'b1;
            end else begin
               load_en  = 1'b1;
               load_val = limit;
               set_wrap = 1'b1;
            end
         end
      end
   end

   genvar k;
   generate
      for (k = 0; k < NS; k++) begin : g_slice
         // Slice k steps only when every lower slice is at its terminal for the direction
         if (k == 0) begin : g_ce0
            assign s_ce[k] = step_en;
         end else begin : g_cek
            assign s_ce[k] = s_ce[k-1] & (ud ? s_tc_up[k-1] : s_tc_dn[k-1]);
         end

         counter_slice u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .ce      (s_ce[k]),
            .ud      (ud),
            .ld      (load_en),
            .din     (load_val[k*SLICE_W +: SLICE_W]),
            .rst_val (RESET_VAL[k*SLICE_W +: SLICE_W]),
            .q       (q[k*SLICE_W +: SLICE_W]),
            .tc_up   (s_tc_up[k]),
            .tc_dn   (s_tc_dn[k])
         );
      end
   endgenerate

   // Status registers: wrap is a one-edge pulse, ovf is sticky until clear or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else if (clr) begin
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         wrap <= set_wrap;
         if (set_ovf) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule
